// File: rtl/button_conditioner.sv
// Pushbutton conditioner: per-channel synchronizer, debouncer and press/auto-repeat
// pulse generator. Each channel is an independent button_lane instance.

module button_lane #(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  input  logic repeat_en,
  output logic level,
  output logic pulse
);
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, REPEAT} state_t;

  logic          s1, s2;
  logic [DW-1:0] db_cnt, db_nxt;
  logic          level_nxt, rise, fall;
  state_t        state, state_nxt;
  logic [HW-1:0] hold, hold_nxt;
  logic          pulse_nxt;

  always_comb begin
    db_nxt    = '0;
    level_nxt = level;
    if (s2 != level) begin
      if (db_cnt == DB_LAST) level_nxt = ~level;
      else                   db_nxt    = db_cnt + DW'(1);
    end
  end

  // FSM reacts to the debounced edge in the same cycle so pulse lines up with level
  assign rise = level_nxt & ~level;
  assign fall = ~level_nxt & level;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = WAIT_FIRST;
          hold_nxt  = '0;
          pulse_nxt = 1'b1;
        end
      end
      WAIT_FIRST: begin
        if (fall) begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end else if (repeat_en) begin
          if (hold == DLY_LAST) begin
            state_nxt = REPEAT;
            hold_nxt  = '0;
            pulse_nxt = 1'b1;
          end else hold_nxt = hold + HW'(1);
        end
      end
      REPEAT: begin
        if (fall) begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end else if (repeat_en) begin
          if (hold == PER_LAST) begin
            hold_nxt  = '0;
            pulse_nxt = 1'b1;
          end else hold_nxt = hold + HW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      db_cnt <= '0;
      level  <= 1'b0;
      state  <= IDLE;
      hold   <= '0;
      pulse  <= 1'b0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      db_cnt <= db_nxt;
      level  <= level_nxt;
      state  <= state_nxt;
      hold   <= hold_nxt;
      pulse  <= pulse_nxt;
    end
  end
endmodule

module button_conditioner #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pb_raw,
  input  logic [WIDTH-1:0] repeat_en,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pulse
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    button_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_lane (
      .clock    (clock),
      .reset    (reset),
      .raw      (pb_raw[i]),
      .repeat_en(repeat_en[i]),
      .level    (level[i]),
      .pulse    (pulse[i])
    );
  end
endmodule
